kga_wide_add_seq: RTL
=====================

Name: kga_wide_add_seq

Overview:
Multi-cycle sequencer that performs wide (8*WORDS-bit) add/subtract by time-multiplexing one 8-bit Kogge-Stone adder (KGA, ports A, B, in_C, S, out_C), instantiated internally.
- Processes one 8-bit limb per cycle, LSB limb first, and chains the carry through a register.
- Sits between a requester (valid/ready command port) and a consumer (valid/ready result port).

Parameters:
WORDS, 4, number of 8-bit limbs; operand width W = 8*WORDS; legal range WORDS >= 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous, active-low
start_valid  input  1  command valid
start_ready  output  1  command accepted when start_valid & start_ready at a clk edge
op_a  input  W  operand A
op_b  input  W  operand B
op_cin  input  1  carry-in for add; ignored for subtract
op_sub  input  1  0 = A+B+cin; 1 = A-B (computed as A+~B+1)
res_valid  output  1  result valid
res_ready  input  1  consumer accepts the result when res_valid & res_ready at a clk edge
res_sum  output  W  result
res_cout  output  1  carry out of MSB (for subtract, 1 = no borrow)
res_ovf  output  1  two's-complement signed overflow
busy  output  1  high when the FSM is not in IDLE

Behaviour:
- One clock; reset is asynchronous and active-low (rst_n); all state is cleared on assertion.
- Reset values: state=IDLE, limb index=0, carry reg=0, res_sum=0, res_cout=0, res_ovf=0, res_valid=0, busy=0. start_ready=1 (combinational from IDLE).

FSM states:
- IDLE
  - start_ready=1.
  - On a start handshake, latch op_a, op_b (inverted when op_sub=1) and op_sub.
  - Set carry = op_sub ? 1 : op_cin; idx=0; go to RUN.
- RUN, one cycle per limb
  - KGA inputs: A=a[8*idx+:8], B=b_eff[8*idx+:8], in_C=carry.
  - At the edge: res_sum[8*idx+:8] <= S; carry <= out_C.
  - At idx=WORDS-1: res_cout <= out_C; res_ovf <= (A[7] ~^ B[7]) & (S[7] ^ A[7]), using limb-level effective operands; go to DONE. Otherwise idx <= idx+1.
- DONE
  - res_valid=1. res_sum, res_cout and res_ovf are held stable.
  - On res_valid & res_ready, go to IDLE.
  - start_ready=0; no overlap of a new command with a pending result.

Latency:
- Start accepted at edge T; RUN occupies edges T+1..T+WORDS.
- res_valid is high from after edge T+WORDS.
- Minimum command-to-command spacing is WORDS+2 cycles (result accepted in the first DONE cycle).

Boundary conditions:
- start_valid while busy: ignored; operands are not sampled, and the requester must hold them.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- res_ready low: DONE is held indefinitely with outputs stable.
- WORDS=1: exactly one RUN cycle.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately, all outputs go to their reset values, and nothing is emitted after release.
- res_sum, res_cout and res_ovf retain the last result in IDLE. They are meaningful only while res_valid=1. Limbs are overwritten progressively during the next RUN.
- Carry chain: the carry of the top limb becomes res_cout. The internal carry does not persist across commands; it is re-initialised on each start.

Test Plan:
1. WORDS=4, A=0x00000000, B=0x00000000, cin=1, add -> sum=0x00000001, cout=0, ovf=0; res_valid rises exactly 4 cycles after the accept edge; busy high throughout.
2. A=0x000000FF, B=0x00000001, cin=0 -> sum=0x00000100, cout=0 (carry crosses limb 0→1). Then A=0xFFFFFFFF, B=0x00000000, cin=1 -> sum=0x00000000, cout=1, ovf=0.
3. A=0x7FFFFFFF, B=0x00000001, add -> sum=0x80000000, cout=0, ovf=1. Then A=0xFFFFFFFF, B=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1, ovf=0.
4. Subtract: A=5, B=7 -> sum=0xFFFFFFFE, cout=0, ovf=0. A=7, B=5 -> sum=0x00000002, cout=1. A=0x80000000, B=1 -> sum=0x7FFFFFFF, ovf=1.
5. Handshake: hold res_ready=0 for 3 cycles in DONE -> res_valid and res_sum stable, start_ready=0. A start_valid pulse with new operands during RUN/DONE is ignored. Raising res_ready returns to IDLE next edge; a new start is accepted on that following cycle.
6. Assert rst_n=0 asynchronously mid-RUN (after limb 1) -> all outputs 0 immediately, start_ready=1 after release, no spurious res_valid. Rerun scenario 1 -> correct result.

Source files
------------

// File: rtl/kga_wide_add_seq.sv
// ---------------------------------------------------------------------------
// kga_wide_add_seq
//   Wide (8*WORDS-bit) add/subtract built from one 8-bit Kogge-Stone adder that
//   is reused once per limb, least-significant limb first. The carry between
//   limbs is kept in a register.
//
//   Ports
//     clk, rst_n            clock, asynchronous active-low reset
//     start_valid/ready     command handshake (ready only while IDLE)
//     op_a, op_b            operands, sampled on the accepting edge
//     op_cin                carry-in for add (ignored for subtract)
//     op_sub                0: A+B+cin, 1: A-B computed as A+~B+1
//     res_valid/ready       result handshake
//     res_sum               W-bit result
//     res_cout              carry out of the MSB (subtract: 1 = no borrow)
//     res_ovf               two's-complement signed overflow
//     busy                  high whenever the sequencer is not IDLE
// ---------------------------------------------------------------------------

// 8-bit Kogge-Stone adder. The carry-in is folded into bit 0's generate term,
// so the carry into bit i is simply the group generate of bits [i-1:0].
module kga (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       in_C,
  output logic [7:0] S,
  output logic       out_C
);

  logic [7:0] p0_s;
  logic [7:0] g0_s;
  logic [7:0] g1_s, p1_s;
  logic [7:0] g2_s, p2_s;
  logic [7:0] g3_s, p3_s;

  assign p0_s = A ^ B;
  assign g0_s = (A & B) | {7'b0000000, (p0_s[0] & in_C)};

  // Prefix level 1 (span 1)
  for (genvar i = 0; i < 8; i++) begin : g_lvl1
    if (i >= 1) begin : g_comb
      assign g1_s[i] = g0_s[i] | (p0_s[i] & g0_s[i-1]);
      assign p1_s[i] = p0_s[i] & p0_s[i-1];
    end else begin : g_pass
      assign g1_s[i] = g0_s[i];
      assign p1_s[i] = p0_s[i];
    end
  end

  // Prefix level 2 (span 2)
  for (genvar i = 0; i < 8; i++) begin : g_lvl2
    if (i >= 2) begin : g_comb
      assign g2_s[i] = g1_s[i] | (p1_s[i] & g1_s[i-2]);
      assign p2_s[i] = p1_s[i] & p1_s[i-2];
    end else begin : g_pass
      assign g2_s[i] = g1_s[i];
      assign p2_s[i] = p1_s[i];
    end
  end

  // Prefix level 3 (span 4)
  for (genvar i = 0; i < 8; i++) begin : g_lvl3
    if (i >= 4) begin : g_comb
      assign g3_s[i] = g2_s[i] | (p2_s[i] & g2_s[i-4]);
      assign p3_s[i] = p2_s[i] & p2_s[i-4];
    end else begin : g_pass
      assign g3_s[i] = g2_s[i];
      assign p3_s[i] = p2_s[i];
    end
  end

  // Top-level group propagate is not needed: in_C is already inside g3_s.
  logic unused_p3_s;
  assign unused_p3_s = ^p3_s;

  assign S     = p0_s ^ {g3_s[6:0], in_C};
  assign out_C = g3_s[7];

endmodule

module kga_wide_add_seq #(
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [8*WORDS-1:0] op_a,
  input  logic [8*WORDS-1:0] op_b,
  input  logic               op_cin,
  input  logic               op_sub,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [8*WORDS-1:0] res_sum,
  output logic               res_cout,
  output logic               res_ovf,
  output logic               busy
);

  localparam int W     = 8 * WORDS;
  localparam int LIMB  = 8;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  // b_q holds the effective operand (already inverted for subtract), so the
  // operation type needs no separate storage.
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

  logic [7:0]       kga_a_s;
  logic [7:0]       kga_b_s;
  logic [7:0]       kga_s_s;
  logic             kga_cout_s;

  assign kga_a_s = a_q[idx_q*LIMB +: LIMB];
  assign kga_b_s = b_q[idx_q*LIMB +: LIMB];

  kga u_kga (
    .A     (kga_a_s),
    .B     (kga_b_s),
    .in_C  (carry_q),
    .S     (kga_s_s),
    .out_C (kga_cout_s)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;

    case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_d     = op_a;
          b_d     = op_sub ? ~op_b : op_b;
          carry_d = op_sub ? 1'b1 : op_cin;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[idx_q*LIMB +: LIMB] = kga_s_s;
        carry_d                   = kga_cout_s;
        if (idx_q == LAST_IDX) begin
          cout_d  = kga_cout_s;
          // Overflow: both effective operands share a sign that the sum lacks.
          ovf_d   = (kga_a_s[7] ~^ kga_b_s[7]) & (kga_s_s[7] ^ kga_a_s[7]);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign res_valid   = res_valid_q;
  assign res_sum     = sum_q;
  assign res_cout    = cout_q;
  assign res_ovf     = ovf_q;
  assign busy        = busy_q;

endmodule
